// File: rtl/data_axi_port.sv
// data_axi_port: data-side memory port of the CPU.
// Takes one load/store from the MEM stage, runs one single-beat AXI4 read or
// write, and stalls the pipeline until it completes. Load data is held on
// dm_rdata until the next completed load so MEM/WB can capture it when the
// pipeline advances out of DONE.
module data_axi_port #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  cpu_clk_50M,
  input  logic                  cpu_rst,
  // MEM stage request
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [1:0]            mem_size,
  input  logic [DATA_W/8-1:0]   mem_bsel,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic                  flush,
  input  logic                  pipe_hold,
  output logic                  stallreq_mem,
  output logic [DATA_W-1:0]     dm_rdata,
  // AR channel
  output logic [ADDR_W-1:0]     araddr,
  output logic [2:0]            arsize,
  output logic                  arvalid,
  input  logic                  arready,
  // R channel
  input  logic [DATA_W-1:0]     rdata,
  input  logic                  rvalid,
  output logic                  rready,
  // AW channel
  output logic [ADDR_W-1:0]     awaddr,
  output logic [2:0]            awsize,
  output logic                  awvalid,
  input  logic                  awready,
  // W channel
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wvalid,
  output logic                  wlast,
  input  logic                  wready,
  // B channel
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW_W = 3'd3,
    ST_B    = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  state_e              state_r;
  state_e              state_next_s;

  // Latched request; only written in IDLE, so payload is stable while any
  // valid is high.
  logic [ADDR_W-1:0]   addr_r;
  logic [1:0]          size_r;
  logic [STRB_W-1:0]   bsel_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                we_r;

  logic                arvalid_r;
  logic                rready_r;
  logic                awvalid_r;
  logic                wvalid_r;
  logic                bready_r;
  logic                aw_done_r;
  logic                w_done_r;
  logic [DATA_W-1:0]   dm_rdata_r;

  logic                accept_s;
  logic                ar_hs_s;
  logic                r_hs_s;
  logic                aw_hs_s;
  logic                w_hs_s;
  logic                b_hs_s;
  logic                aw_fin_s;
  logic                w_fin_s;
  logic                stallreq_s;

  assign accept_s = mem_req & ~flush;
  assign ar_hs_s  = arvalid_r & arready;
  assign r_hs_s   = rready_r & rvalid;
  assign aw_hs_s  = awvalid_r & awready;
  assign w_hs_s   = wvalid_r & wready;
  assign b_hs_s   = bready_r & bvalid;
  // AW and W may complete in either order or together.
  assign aw_fin_s = aw_done_r | aw_hs_s;
  assign w_fin_s  = w_done_r | w_hs_s;

  // State register.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (mem_we) begin
            state_next_s = ST_AW_W;
          end else begin
            state_next_s = ST_AR;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_AR: begin
        if (ar_hs_s) begin
          state_next_s = ST_R;
        end else begin
          state_next_s = ST_AR;
        end
      end
      ST_R: begin
        if (r_hs_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_R;
        end
      end
      ST_AW_W: begin
        if (aw_fin_s && w_fin_s) begin
          state_next_s = ST_B;
        end else begin
          state_next_s = ST_AW_W;
        end
      end
      ST_B: begin
        if (b_hs_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_B;
        end
      end
      ST_DONE: begin
        if (pipe_hold) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Stall request: combinational on the request in IDLE so the MEM stage is
  // frozen in the same cycle it issues; held through the transaction.
  always_comb begin
    stallreq_s = 1'b0;
    if (cpu_rst) begin
      stallreq_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: stallreq_s = accept_s;
        ST_AR:   stallreq_s = 1'b1;
        ST_R:    stallreq_s = 1'b1;
        ST_AW_W: stallreq_s = 1'b1;
        ST_B:    stallreq_s = 1'b1;
        ST_DONE: stallreq_s = 1'b0;
        default: stallreq_s = 1'b0;
      endcase
    end
  end

  // Request latch, AXI valid/ready flops and load-data register.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      addr_r     <= {ADDR_W{1'b0}};
      size_r     <= 2'b00;
      bsel_r     <= {STRB_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      we_r       <= 1'b0;
      arvalid_r  <= 1'b0;
      rready_r   <= 1'b0;
      awvalid_r  <= 1'b0;
      wvalid_r   <= 1'b0;
      bready_r   <= 1'b0;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
      dm_rdata_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            addr_r  <= mem_addr;
            size_r  <= mem_size;
            bsel_r  <= mem_bsel;
            wdata_r <= mem_wdata;
            we_r    <= mem_we;
            if (mem_we) begin
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              aw_done_r <= 1'b0;
              w_done_r  <= 1'b0;
            end else begin
              arvalid_r <= 1'b1;
            end
          end
        end
        ST_AR: begin
          if (ar_hs_s) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
          end
        end
        ST_R: begin
          if (r_hs_s) begin
            rready_r <= 1'b0;
            if (!we_r) begin
              dm_rdata_r <= rdata;
            end
          end
        end
        ST_AW_W: begin
          if (aw_hs_s) begin
            awvalid_r <= 1'b0;
            aw_done_r <= 1'b1;
          end
          if (w_hs_s) begin
            wvalid_r <= 1'b0;
            w_done_r <= 1'b1;
          end
          if (aw_fin_s && w_fin_s) begin
            bready_r <= 1'b1;
          end
        end
        ST_B: begin
          if (b_hs_s) begin
            bready_r <= 1'b0;
          end
        end
        ST_DONE: begin
          arvalid_r <= 1'b0;
        end
        default: begin
          arvalid_r <= 1'b0;
        end
      endcase
    end
  end

  assign stallreq_mem = stallreq_s;
  assign dm_rdata     = dm_rdata_r;
  assign araddr       = addr_r;
  assign arsize       = {1'b0, size_r};
  assign arvalid      = arvalid_r;
  assign rready       = rready_r;
  assign awaddr       = addr_r;
  assign awsize       = {1'b0, size_r};
  assign awvalid      = awvalid_r;
  assign wdata        = wdata_r;
  assign wstrb        = bsel_r;
  assign wvalid       = wvalid_r;
  assign wlast        = wvalid_r;
  assign bready       = bready_r;

endmodule
